noc_flit_arbiter: RTL and testbench
===================================

Name: noc_flit_arbiter

Overview:
- Round-robin, packet-aware arbiter that shares one router output port among num_req input FIFOs.
- Each input FIFO presents a data/valid head and accepts a deq strobe. The arbiter drains the FIFOs into a single registered output stage that feeds a downstream FIFO through its enq/full interface.
- The lock is held from head flit to tail flit. A max-packet-length guard stops a misbehaving requester from holding the port indefinitely.

Parameters:
num_req, 4, number of requesters
req_bits, 2, width of a requester index (clog2 of num_req)
flit_width, 32, flit width; bit flit_width-1 is the tail flag
max_pkt, 16, maximum flits per packet before a forced release
cnt_bits, 5, width of the flit counter (must hold max_pkt)

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
req_valid  in  num_req  head flit valid, per requester
req_data  in  num_req*flit_width  head flits; requester i occupies bits [i*flit_width +: flit_width]
req_deq  out  num_req  combinational pop strobe, one-hot or zero
out_data  out  flit_width  registered flit to the downstream FIFO
out_enq  out  1  registered valid flit to the downstream FIFO
out_full  in  1  downstream FIFO full
grant_id  out  req_bits  current or last granted requester
locked  out  1  high while in the LOCKED state
viol  out  1  one-cycle pulse on a max-length violation
viol_id  out  req_bits  offending requester, held until the next violation

Behaviour:
- Reset: out_enq=0, out_data=0, grant_id=0, locked=0, viol=0, viol_id=0, rr_ptr=0, flit_cnt=0, state=IDLE.
  - req_deq=0 during any reset cycle.
  - Reset mid-packet drops the lock. A flit held in the output register is discarded.
- Output stage:
  - can_load = !out_enq || !out_full.
  - Downstream consumes a flit on any cycle where out_enq && !out_full.
  - If there is no load and the flit is consumed, out_enq<=0.
  - If !can_load, out_data and out_enq hold and no req_deq is issued.
- Load action on a requester w:
  - req_deq[w]=1 in the same cycle.
  - On the next edge: out_data<=req_data[w], out_enq<=1, grant_id<=w.
  - A load happens only when can_load && req_valid[w].
- IDLE state:
  - Winner = first requester with req_valid set, searching rr_ptr, rr_ptr+1, … with wrap-around modulo num_req (explicit wrap; num_req need not be a power of 2).
  - On load, flit_cnt<=1.
  - Tail bit set (single-flit packet): stay IDLE, rr_ptr<=(w+1) mod num_req.
  - Tail bit clear: go to LOCKED.
- LOCKED state:
  - Only requester grant_id is eligible. Other requesters are never dequeued, even when grant_id is not valid.
  - On load: flit_cnt<=flit_cnt+1.
  - Tail flit: go to IDLE, rr_ptr<=(grant_id+1) mod num_req.
  - Non-tail flit with flit_cnt+1==max_pkt: the flit is still forwarded. On the next edge viol<=1 and viol_id<=grant_id, go to IDLE, rr_ptr<=(grant_id+1) mod num_req.
  - Remaining flits of the offending packet arrive later as a new packet and arbitrate normally.
- Latency: one cycle from req_deq to out_enq. Back-to-back sustains one flit per cycle while out_full=0.
- A requester with req_valid=0 is never dequeued. Simultaneous tail flit and max-length hit: tail wins, no viol.

Test Plan:
- Assert reset for 2 cycles with all req_valid=1 -> req_deq=0 throughout; all outputs 0 the cycle after reset deasserts, then grant 0 first.
- All 4 requesters stream single-flit packets (tail=1), out_full=0 -> req_deq sequence 0001,0010,0100,1000,0001; out_enq continuous; grant_id 0,1,2,3,0.
- Req1 sends a 3-flit packet 0x00000A01, 0x00000A02, 0x80000A03 while req2 is valid -> req2 not dequeued until the tail is loaded, locked=1 for those cycles, next grant=2.
- out_full=1 for 3 cycles while out_enq=1 holding 0x12345678 -> out_data stable, req_deq=0; after release the flow resumes with no lost or duplicated flit.
- With max_pkt=16, req0 sends 20 non-tail flits while req3 is valid -> viol pulses for one cycle after the 16th load with viol_id=0; next grant=3; req0 is re-granted afterwards.
- Reset asserted mid-packet during LOCKED on req2 -> locked=0, rr_ptr=0; after reset deasserts with req0 and req2 both valid, grant=0.

Source files
------------

// File: rtl/noc_flit_arbiter.sv
// Packet-aware round-robin arbiter draining num_req input FIFO heads into one
// registered output flit stage, with a max-packet-length guard on the lock.
module noc_flit_arbiter #(
    parameter int num_req    = 4,
    parameter int req_bits   = 2,
    parameter int flit_width = 32,
    parameter int max_pkt    = 16,
    parameter int cnt_bits   = 5
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [num_req-1:0]            req_valid,
    input  logic [num_req*flit_width-1:0] req_data,
    output logic [num_req-1:0]            req_deq,
    output logic [flit_width-1:0]         out_data,
    output logic                          out_enq,
    input  logic                          out_full,
    output logic [req_bits-1:0]           grant_id,
    output logic                          locked,
    output logic                          viol,
    output logic [req_bits-1:0]           viol_id
);

    localparam logic [0:0] st_idle   = 1'b0;
    localparam logic [0:0] st_locked = 1'b1;

    logic [0:0]            state;
    logic [req_bits-1:0]   rr_ptr;
    logic [cnt_bits-1:0]   flit_cnt;
    logic [req_bits-1:0]   win;
    logic [req_bits-1:0]   cand;
    logic [req_bits-1:0]   next_ptr;
    logic                  found;
    logic                  can_load;
    logic                  load;
    logic                  tail;
    logic                  cnt_hit;
    logic [flit_width-1:0] sel_flit;
    logic [flit_width-1:0] heads [num_req];
    int                    idx;

    for (genvar i = 0; i < num_req; i++) begin : g_heads
        assign heads[i] = req_data[i*flit_width +: flit_width];
    end

    // Winner search walks downward so the lowest offset from rr_ptr is kept;
    // the wrap is explicit so num_req need not be a power of two.
    always_comb begin
        found = 1'b0;
        win   = rr_ptr;
        idx   = 0;
        cand  = '0;
        if (state == st_locked) begin
            win   = grant_id;
            found = req_valid[grant_id];
        end else begin
            for (int k = num_req - 1; k >= 0; k--) begin
                idx = int'(rr_ptr) + k;
                if (idx >= num_req) idx = idx - num_req;
                cand = req_bits'(idx);
                if (req_valid[cand]) begin
                    found = 1'b1;
                    win   = cand;
                end
            end
        end
    end

    assign sel_flit = heads[win];
    assign tail     = sel_flit[flit_width-1];
    assign can_load = !out_enq || !out_full;
    assign load     = !reset && can_load && found;
    assign next_ptr = (win == req_bits'(num_req - 1)) ? '0 : win + 1'b1;
    assign cnt_hit  = (flit_cnt + 1'b1) == cnt_bits'(max_pkt);
    assign locked   = (state == st_locked);

    always_comb begin
        req_deq = '0;
        if (load) req_deq[win] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= st_idle;
            rr_ptr   <= '0;
            flit_cnt <= '0;
            out_data <= '0;
            out_enq  <= 1'b0;
            grant_id <= '0;
            viol     <= 1'b0;
            viol_id  <= '0;
        end else begin
            viol <= 1'b0;
            if (load) begin
                out_data <= sel_flit;
                out_enq  <= 1'b1;
                grant_id <= win;
                if (state == st_idle) begin
                    flit_cnt <= cnt_bits'(1);
                    if (tail) rr_ptr <= next_ptr;
                    else      state  <= st_locked;
                end else begin
                    flit_cnt <= flit_cnt + 1'b1;
                    // Tail takes priority over the length guard.
                    if (tail) begin
                        state  <= st_idle;
                        rr_ptr <= next_ptr;
                    end else if (cnt_hit) begin
                        state   <= st_idle;
                        rr_ptr  <= next_ptr;
                        viol    <= 1'b1;
                        viol_id <= win;
                    end
                end
            end else if (out_enq && !out_full) begin
                out_enq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_noc_flit_arbiter.sv
// Randomized bench for noc_flit_arbiter: source FIFOs as queues, a
// packet-level reference model, and an output scoreboard.
module tb_noc_flit_arbiter;

    localparam int NR      = 4;
    localparam int FW      = 32;
    localparam int MAX_PKT = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*FW-1:0]  req_data = '0;
    logic [NR-1:0]     req_deq;
    logic [FW-1:0]     out_data;
    logic              out_enq;
    logic              out_full = 1'b0;
    logic [1:0]        grant_id;
    logic              locked;
    logic              viol;
    logic [1:0]        viol_id;

    noc_flit_arbiter #(
        .num_req(NR), .req_bits(2), .flit_width(FW), .max_pkt(MAX_PKT), .cnt_bits(5)
    ) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_deq(req_deq), .out_data(out_data), .out_enq(out_enq), .out_full(out_full),
        .grant_id(grant_id), .locked(locked), .viol(viol), .viol_id(viol_id)
    );

    always #5 clock = ~clock;

    logic [FW-1:0] src [NR][$];
    logic [FW-1:0] exp_q [$];

    // Reference model: owner is the requester holding the port, -1 when free.
    int            m_rr, m_owner, m_cnt, m_grant, m_viol_id;
    logic          m_out_enq, m_viol;
    logic [FW-1:0] m_out_data;

    int            n_checks = 0;
    int            n_fail = 0;
    int            viol_seen = 0;
    int            last_viol_id = 0;
    logic [NR-1:0] last_deq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_owner = -1; m_cnt = 0; m_grant = 0; m_viol_id = 0;
        m_out_enq = 1'b0; m_viol = 1'b0; m_out_data = '0;
        exp_q.delete();
    endtask

    task automatic drive_heads();
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = (src[i].size() != 0);
            req_data[i*FW +: FW] = req_valid[i] ? src[i][0] : $urandom();
        end
    endtask

    task automatic check_outputs();
        check("out_enq", 32'(out_enq), 32'(m_out_enq));
        if (m_out_enq) check("out_data", out_data, m_out_data);
        check("grant_id", 32'(grant_id), 32'(m_grant));
        check("locked", 32'(locked), 32'(m_owner >= 0));
        check("viol", 32'(viol), 32'(m_viol));
        check("viol_id", 32'(viol_id), 32'(m_viol_id));
        if (viol) begin
            viol_seen++;
            last_viol_id = int'(viol_id);
        end
    endtask

    task automatic reset_cycle();
        @(negedge clock);
        reset = 1'b1;
        out_full = 1'b0;
        drive_heads();
        #1;
        check("deq_in_reset", 32'(req_deq), 32'd0);
        @(posedge clock);
        model_reset();
        #1;
        check("rst_out_enq", 32'(out_enq), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_viol", 32'(viol), 32'd0);
        check("rst_viol_id", 32'(viol_id), 32'd0);
    endtask

    task automatic step(input logic full);
        int            pick;
        int            r;
        logic [NR-1:0] exp_deq;
        logic [FW-1:0] flit;
        @(negedge clock);
        reset = 1'b0;
        out_full = full;
        drive_heads();
        #1;
        pick = -1;
        if (!m_out_enq || !full) begin
            if (m_owner >= 0) begin
                if (src[m_owner].size() != 0) pick = m_owner;
            end else begin
                for (int k = 0; k < NR; k++) begin
                    r = (m_rr + k) % NR;
                    if (pick < 0 && src[r].size() != 0) pick = r;
                end
            end
        end
        exp_deq = '0;
        if (pick >= 0) exp_deq[pick] = 1'b1;
        check("req_deq", 32'(req_deq), 32'(exp_deq));
        last_deq = req_deq;
        if (out_enq && !out_full) begin
            if (exp_q.size() != 0) check("sb_flit", out_data, exp_q.pop_front());
            else check("sb_extra_flit", 32'(out_enq), 32'd0);
        end
        @(posedge clock);
        m_viol = 1'b0;
        if (pick >= 0) begin
            flit = src[pick][0];
            exp_q.push_back(flit);
            m_out_data = flit;
            m_out_enq = 1'b1;
            m_grant = pick;
            if (m_owner < 0) begin
                m_cnt = 1;
                if (flit[FW-1]) m_rr = (pick + 1) % NR;
                else m_owner = pick;
            end else begin
                m_cnt++;
                if (flit[FW-1]) begin
                    m_owner = -1;
                    m_rr = (pick + 1) % NR;
                end else if (m_cnt == MAX_PKT) begin
                    m_viol = 1'b1;
                    m_viol_id = pick;
                    m_owner = -1;
                    m_rr = (pick + 1) % NR;
                end
            end
        end else if (m_out_enq && !full) begin
            m_out_enq = 1'b0;
        end
        for (int i = 0; i < NR; i++)
            if (last_deq[i] && src[i].size() != 0) void'(src[i].pop_front());
        #1;
        check_outputs();
    endtask

    function automatic logic any_pending();
        logic p = m_out_enq;
        for (int i = 0; i < NR; i++) if (src[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic drain();
        int n = 0;
        while (any_pending() && n < 4000) begin
            step(1'b0);
            n++;
        end
        check("drain_done", 32'(any_pending()), 32'd0);
    endtask

    task automatic push_packet(input int q, input int len, input logic [15:0] tag);
        for (int k = 0; k < len - 1; k++) src[q].push_back({1'b0, 15'($urandom()), tag});
        src[q].push_back({1'b1, 15'($urandom()), tag});
    endtask

    logic [NR-1:0] seq_exp [5];
    int            v0;
    int            n;

    initial begin
        model_reset();
        seq_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NR; i++) src[i].push_back(32'h8000_0000 | (i << 8) | r);

        reset_cycle();
        reset_cycle();

        for (int k = 0; k < 5; k++) begin
            step(1'b0);
            check("rr_seq", 32'(last_deq), 32'(seq_exp[k]));
            check("rr_stream_enq", 32'(out_enq), 32'd1);
        end
        drain();

        src[1].push_back(32'h0000_0A01);
        src[1].push_back(32'h0000_0A02);
        src[1].push_back(32'h8000_0A03);
        src[2].push_back(32'h8000_0B01);
        for (int k = 0; k < 3; k++) begin
            step(1'b0);
            check("pkt_deq_req1", 32'(last_deq), 32'b0010);
        end
        step(1'b0);
        check("pkt_next_grant", 32'(grant_id), 32'd2);
        drain();

        src[0].push_back(32'h1234_5678);
        src[0].push_back(32'h8000_0001);
        step(1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1);
            check("full_hold_data", out_data, 32'h1234_5678);
            check("full_no_deq", 32'(last_deq), 32'd0);
        end
        drain();

        v0 = viol_seen;
        for (int k = 0; k < 20; k++) src[0].push_back(32'h0000_0100 + k);
        src[0].push_back(32'h8000_0200);
        step(1'b0);
        src[3].push_back(32'h8000_0300);
        n = 0;
        while (viol_seen == v0 && n < 40) begin
            step(1'b0);
            n++;
        end
        check("viol_pulses", 32'(viol_seen - v0), 32'd1);
        check("viol_id_val", 32'(last_viol_id), 32'd0);
        step(1'b0);
        check("viol_next_grant", 32'(grant_id), 32'd3);
        step(1'b0);
        check("viol_regrant", 32'(grant_id), 32'd0);
        drain();

        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                v0 = $urandom_range(0, NR - 1);
                if (src[v0].size() < 40) push_packet(v0, $urandom_range(1, 20), 16'(c));
            end
            step($urandom_range(0, 3) == 0);
        end
        drain();

        push_packet(2, 7, 16'hC200);
        n = 0;
        while (m_owner != 2 && n < 20) begin
            step(1'b0);
            n++;
        end
        step(1'b0);
        check("mid_pkt_locked", 32'(locked), 32'd1);
        reset_cycle();
        src[0].push_back(32'h8000_C000);
        step(1'b0);
        check("grant_after_reset", 32'(grant_id), 32'd0);
        drain();

        check("sb_left_over", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
